clock_hms_param: RTL

CLOCK_HMS_PARAM -- requirements
Module: clock_hms_param

---
 rtl/clock_hms_param.sv | 137 +++++++++++++
 1 files changed

// File: rtl/clock_hms_param.sv
`default_nettype none
// ============================================================================
//  Module      : clock_hms_param
//  Description : Hours/minutes/seconds/sub-second clock with load, alarm and
//                selectable 12/24-hour display encoding.
//  Revision    : 1.0  initial release
// ============================================================================
module clock_hms_param #(
  parameter int SUB_COUNT = 60,
  parameter int SUB_W     = 10
) (
  input  logic              kh_clk,
  input  logic              reset_n,
  input  logic              tick_en,
  input  logic              mode_24,
  input  logic              load,
  input  logic [4:0]        load_hr,
  input  logic [5:0]        load_min,
  input  logic [5:0]        load_sec,
  input  logic              alarm_set,
  input  logic [4:0]        alarm_hr,
  input  logic [5:0]        alarm_min,
  input  logic              alarm_en,
  output logic [16+SUB_W:0] disp_time,
  output logic              pm,
  output logic              sec_pulse,
  output logic              alarm_hit,
  output logic              load_err
);

  localparam logic [SUB_W-1:0] c_sub_max = SUB_W'(SUB_COUNT - 1);

  logic [4:0]       r_hr24;
  logic [5:0]       r_min;
  logic [5:0]       r_sec;
  logic [SUB_W-1:0] r_sub;
  logic [4:0]       r_alarm_hr;
  logic [5:0]       r_alarm_min;
  logic             r_sec_evt;
  logic             r_alarm_evt;

  logic [4:0]       w_nxt_hr;
  logic [5:0]       w_nxt_min;
  logic [5:0]       w_nxt_sec;
  logic [SUB_W-1:0] w_nxt_sub;
  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_alarm_ok;
  logic             w_alarm_bad;
  logic             w_adv;
  logic             w_sub_wrap;
  logic             w_alarm_match;
  logic [4:0]       w_hr12;
  logic [4:0]       w_disp_hr;

  assign w_load_ok   = load && (load_hr <= 5'd23) && (load_min <= 6'd59) && (load_sec <= 6'd59);
  assign w_load_bad  = load && !w_load_ok;
  assign w_alarm_ok  = alarm_set && (alarm_hr <= 5'd23) && (alarm_min <= 6'd59);
  assign w_alarm_bad = alarm_set && !w_alarm_ok;
  // Any load request, even a rejected one, blocks the tick for that cycle.
  assign w_adv       = tick_en && !load;
  assign w_sub_wrap  = (r_sub == c_sub_max);

  always_comb begin
    w_nxt_hr  = r_hr24;
    w_nxt_min = r_min;
    w_nxt_sec = r_sec;
    w_nxt_sub = r_sub;
    if (w_load_ok) begin
      w_nxt_hr  = load_hr;
      w_nxt_min = load_min;
      w_nxt_sec = load_sec;
      w_nxt_sub = '0;
    end else if (w_adv) begin
      if (!w_sub_wrap) begin
        w_nxt_sub = r_sub + SUB_W'(1);
      end else begin
        w_nxt_sub = '0;
        if (r_sec != 6'd59) begin
          w_nxt_sec = r_sec + 6'd1;
        end else begin
          w_nxt_sec = 6'd0;
          if (r_min != 6'd59) begin
            w_nxt_min = r_min + 6'd1;
          end else begin
            w_nxt_min = 6'd0;
            w_nxt_hr  = (r_hr24 == 5'd23) ? 5'd0 : r_hr24 + 5'd1;
          end
        end
      end
    end
  end

  assign w_alarm_match = w_adv && alarm_en &&
                         (w_nxt_hr == r_alarm_hr) && (w_nxt_min == r_alarm_min) &&
                         (w_nxt_sec == 6'd0) && (w_nxt_sub == '0);

  assign w_hr12    = (r_hr24 >= 5'd12) ? r_hr24 - 5'd12 : r_hr24;
  assign w_disp_hr = mode_24 ? r_hr24 : ((w_hr12 == 5'd0) ? 5'd12 : w_hr12);

  // Event flags are staged one cycle so pulses line up with the display pipeline.
  always_ff @(posedge kh_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hr24      <= '0;
      r_min       <= '0;
      r_sec       <= '0;
      r_sub       <= '0;
      r_alarm_hr  <= '0;
      r_alarm_min <= '0;
      r_sec_evt   <= 1'b0;
      r_alarm_evt <= 1'b0;
      disp_time   <= '0;
      pm          <= 1'b0;
      sec_pulse   <= 1'b0;
      alarm_hit   <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      r_hr24      <= w_nxt_hr;
      r_min       <= w_nxt_min;
      r_sec       <= w_nxt_sec;
      r_sub       <= w_nxt_sub;
      if (w_alarm_ok) begin
        r_alarm_hr  <= alarm_hr;
        r_alarm_min <= alarm_min;
      end
      r_sec_evt   <= w_adv && w_sub_wrap;
      r_alarm_evt <= w_alarm_match;
      disp_time   <= {w_disp_hr, r_min, r_sec, r_sub};
      pm          <= (r_hr24 >= 5'd12);
      sec_pulse   <= r_sec_evt;
      alarm_hit   <= r_alarm_evt;
      load_err    <= w_load_bad || w_alarm_bad;
    end
  end

endmodule
`default_nettype wire
